psdsqrt_seq: RTL and testbench



---
 rtl/psdsqrt_seq.sv | 120 ++++++++++++
 tb/tb_psdsqrt_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/psdsqrt_seq.sv
// Sequential integer square root: floor root and remainder, one root bit per clock, MSB first.
// Latency SQW cycles from accepting edge to done; start ignored while busy, accepted in the done cycle.
// Optional round-to-nearest root via PSDSQRT_SEQ_ROUND_EN (remainder stays floor-based).
module psdsqrt_seq #(
  parameter int XW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [XW-1:0]   xin,
  output logic            busy,
  output logic            done,
  output logic [XW/2-1:0] sqrt,
  output logic [XW/2:0]   rem
);

  localparam int SQW = XW / 2;
  localparam int CW  = (SQW > 1) ? $clog2(SQW) : 1;
  localparam logic [CW-1:0]  LAST = CW'(SQW - 1);
  localparam logic [SQW-1:0] TOP  = SQW'(1) << (SQW - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [XW-1:0]  op;
  logic [XW-1:0]  psq;
  logic [SQW-1:0] partial;
  logic [SQW-1:0] trial;
  logic [CW-1:0]  cnt;
  logic           load;
  logic           last;

  logic [SQW-1:0] test;
  logic [XW-1:0]  test_ext;
  logic [XW-1:0]  test_sq;
  logic           fit;
  logic [SQW-1:0] part_nxt;
  logic [XW-1:0]  psq_nxt;
  logic [SQW:0]   rem_nxt;
  logic [SQW-1:0] root_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // psq tracks partial^2 so the remainder needs no second squarer.
  always_comb begin
    test     = partial | trial;
    test_ext = XW'(test);
    test_sq  = test_ext * test_ext;
    fit      = (op >= test_sq);
    part_nxt = fit ? test : partial;
    psq_nxt  = fit ? test_sq : psq;
    rem_nxt  = op[SQW:0] - psq_nxt[SQW:0];
`ifdef PSDSQRT_SEQ_ROUND_EN
    if ((rem_nxt > {1'b0, part_nxt}) && (part_nxt != {SQW{1'b1}}))
      root_out = part_nxt + SQW'(1);
    else
      root_out = part_nxt;
`else
    root_out = part_nxt;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op      <= '0;
      psq     <= '0;
      partial <= '0;
      trial   <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      sqrt    <= '0;
      rem     <= '0;
    end else begin
      done <= last;
      if (load) begin
        op      <= xin;
        psq     <= '0;
        partial <= '0;
        trial   <= TOP;
        cnt     <= '0;
      end else if (state == RUN) begin
        partial <= part_nxt;
        psq     <= psq_nxt;
        trial   <= trial >> 1;
        cnt     <= cnt + CW'(1);
      end
      if (last) begin
        sqrt <= root_out;
        rem  <= rem_nxt;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_psdsqrt_seq.sv
// Directed + randomized bench for psdsqrt_seq at XW=32 and XW=8 against an arithmetic reference.
module tb_psdsqrt_seq;

`ifdef PSDSQRT_SEQ_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        start32, busy32, done32;
  logic [31:0] xin32;
  logic [15:0] sqrt32;
  logic [16:0] rem32;
  logic        start8, busy8, done8;
  logic [7:0]  xin8;
  logic [3:0]  sqrt8;
  logic [4:0]  rem8;

  int checks   = 0;
  int failures = 0;

  psdsqrt_seq #(.XW(32)) u32 (
    .clock(clock), .reset(reset), .start(start32), .xin(xin32),
    .busy(busy32), .done(done32), .sqrt(sqrt32), .rem(rem32)
  );

  psdsqrt_seq #(.XW(8)) u8 (
    .clock(clock), .reset(reset), .start(start8), .xin(xin8),
    .busy(busy8), .done(done8), .sqrt(sqrt8), .rem(rem8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Integer bisection for floor(sqrt(x)); x < 2^32 so the root is below 65536.
  function automatic longint unsigned floor_root(input longint unsigned x);
    longint unsigned lo = 0;
    longint unsigned hi = 65536;
    longint unsigned mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else                hi = mid;
    end
    return lo;
  endfunction

  function automatic longint unsigned model_sqrt(input longint unsigned x, input int sqw);
    longint unsigned r    = floor_root(x);
    longint unsigned rmax = (64'd1 << sqw) - 1;
    if (RND && ((r + 1) * (r + 1) - x < x - r * r)) r = r + 1;
    if (r > rmax) r = rmax;
    return r;
  endfunction

  function automatic longint unsigned model_rem(input longint unsigned x);
    longint unsigned r = floor_root(x);
    return x - r * r;
  endfunction

  task automatic wait32(input string tag, input int exp_lat, input logic [31:0] x);
    int lat  = 0;
    bit seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      seen = done32;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_sqrt"}, sqrt32, model_sqrt(x, 16));
    check({tag, "_rem"}, rem32, model_rem(x));
    check({tag, "_busy_low"}, busy32, 0);
  endtask

  task automatic op32(input logic [31:0] x, input string tag);
    @(negedge clock);
    start32 = 1'b1;
    xin32   = x;
    @(posedge clock); #1;
    start32 = 1'b0;
    xin32   = $urandom;
    check({tag, "_busy"}, busy32, 1);
    wait32(tag, 16, x);
  endtask

  task automatic op8(input logic [7:0] x, input string tag);
    int lat  = 0;
    bit seen = 0;
    @(negedge clock);
    start8 = 1'b1;
    xin8   = x;
    @(posedge clock); #1;
    start8 = 1'b0;
    xin8   = 8'($urandom);
    while (!seen && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      seen = done8;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sqrt"}, sqrt8, model_sqrt(x, 4));
    check({tag, "_rem"}, rem8, model_rem(x));
  endtask

  initial begin
    logic [31:0] sq;
    int          r;
    int          ndone;

    start32 = 1'b0; xin32 = '0;
    start8  = 1'b0; xin8  = '0;

    // Asynchronous reset between edges must clear outputs at once.
    #3 reset = 1'b1;
    #1;
    check("rst_busy", busy32, 0);
    check("rst_done", done32, 0);
    check("rst_sqrt", sqrt32, 0);
    check("rst_rem", rem32, 0);
    check("rst_busy8", busy8, 0);
    check("rst_sqrt8", sqrt8, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      check("idle_busy", busy32, 0);
    end

    op32(32'd99, "x99");
    check("x99_sqrt_lit", sqrt32, RND ? 10 : 9);
    check("x99_rem_lit", rem32, 18);
    op32(32'd100, "x100");
    check("x100_sqrt_lit", sqrt32, 10);
    check("x100_rem_lit", rem32, 0);
    op32(32'd0, "x0");
    check("x0_sqrt_lit", sqrt32, 0);
    op32(32'hFFFF_FFFF, "xmax");
    check("xmax_sqrt_lit", sqrt32, 65535);
    check("xmax_rem_lit", rem32, 131070);

    // Start while busy is ignored.
    @(negedge clock);
    start32 = 1'b1; xin32 = 32'd200;
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    start32 = 1'b1; xin32 = 32'd5;
    @(posedge clock); #1;
    start32 = 1'b0;
    check("ign_busy", busy32, 1);
    wait32("ign", 11, 32'd200);
    check("ign_sqrt_lit", sqrt32, 14);
    check("ign_rem_lit", rem32, 4);

    // Start in the done cycle is accepted.
    start32 = 1'b1; xin32 = 32'd5;
    @(posedge clock); #1;
    start32 = 1'b0;
    check("b2b_done_drop", done32, 0);
    check("b2b_busy", busy32, 1);
    wait32("b2b", 16, 32'd5);
    check("b2b_sqrt_lit", sqrt32, 2);

    // Reset mid-operation discards the in-flight result.
    @(negedge clock);
    start32 = 1'b1; xin32 = 32'd1000;
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (6) begin @(posedge clock); #1; end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy32, 0);
    check("mid_rst_done", done32, 0);
    check("mid_rst_sqrt", sqrt32, 0);
    check("mid_rst_rem", rem32, 0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    repeat (24) begin
      @(posedge clock); #1;
      if (done32) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    check("mid_rst_sqrt_hold", sqrt32, 0);
    op32(32'd1000, "x1000");
    check("x1000_sqrt_lit", sqrt32, RND ? 32 : 31);
    check("x1000_rem_lit", rem32, 39);

    repeat (12) op32($urandom, "rand");
    repeat (6) begin
      r  = $urandom_range(1, 65535);
      sq = 32'(r * r);
      op32(sq, "sq");
      op32(sq - 32'd1, "sqm1");
    end

    op8(8'd200, "x8_200");
    check("x8_200_sqrt_lit", sqrt8, 14);
    check("x8_200_rem_lit", rem8, 4);
    op8(8'd255, "x8_255");
    check("x8_255_sqrt_lit", sqrt8, 15);
    check("x8_255_rem_lit", rem8, 30);
    for (int v = 0; v < 256; v++) op8(8'(v), $sformatf("x8_%0d", v));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
